// File: rtl/trng_byte_fetcher.sv
// trng_byte_fetcher
// Fetches one byte at a time from an entropy vector buffer and hands it to
// a consumer over a valid/ready port. A request that goes unanswered for
// TIMEOUT_CYCLES cycles latches a sticky timeout fault.
//
// Build option: define TRNG_FETCH_HEALTH_TEST_EN to add the repetition
// count health test. When it is defined, a run of RCT_LIMIT identical
// captured bytes latches a sticky repetition fault. When it is undefined,
// every captured byte is delivered and only the timeout fault can occur.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | nothing pending, a new request starts on the next edge
// ST_REQ   | load the timeout counter and raise vec_req
// ST_WAIT  | vec_req high, counting down and waiting for vec_valid
// ST_HOLD  | out_data/out_valid presented until the consumer accepts
// ST_FAULT | sticky fault; only rst leaves this state

module trng_byte_fetcher #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RCT_LIMIT      = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       vec_req,
  input  logic [7:0] vec_in,
  input  logic       vec_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_REPEAT  = 2'b10;

  localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CYCLES);

  localparam bit PARAMS_OK = (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 255) &&
                             (RCT_LIMIT >= 2) && (RCT_LIMIT <= 15);

  // Refuse to elaborate with parameters the counters cannot represent.
  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("trng_byte_fetcher: TIMEOUT_CYCLES must be 1..255 and RCT_LIMIT 2..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] tmo_cnt;
  logic       capture;
  logic       rep_trip;

  // A capture is only possible while the request is outstanding.
  assign capture = (state == ST_WAIT) && vec_valid;

`ifdef TRNG_FETCH_HEALTH_TEST_EN
  localparam logic [3:0] RCT_MAX = 4'(RCT_LIMIT);

  logic [7:0] prev_byte;
  logic [3:0] run_cnt;
  logic [3:0] run_next;

  // Run length the current byte would produce; run_cnt == 0 means no byte
  // has been captured since reset, so there is nothing to compare against.
  always_comb begin
    run_next = 4'd1;
    if ((run_cnt != 4'd0) && (vec_in == prev_byte)) begin
      run_next = run_cnt + 4'd1;
    end
    rep_trip = (run_next == RCT_MAX);
  end

  // Track the previous captured byte and the length of its run.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_byte <= 8'h00;
      run_cnt   <= 4'd0;
    end else if (capture) begin
      prev_byte <= vec_in;
      run_cnt   <= run_next;
    end
  end
`else
  assign rep_trip = 1'b0;
`endif

  // Request/capture/handoff sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tmo_cnt    <= 8'd0;
      vec_req    <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= CODE_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!out_valid && !fault) begin
            state <= ST_REQ;
          end
        end

        ST_REQ: begin
          vec_req <= 1'b1;
          tmo_cnt <= TIMEOUT_LOAD;
          state   <= ST_WAIT;
        end

        ST_WAIT: begin
          tmo_cnt <= tmo_cnt - 8'd1;
          // A byte arriving on the terminal-count edge still wins over the
          // timeout, so vec_valid is tested first.
          if (capture) begin
            vec_req <= 1'b0;
            if (rep_trip) begin
              fault      <= 1'b1;
              fault_code <= CODE_REPEAT;
              state      <= ST_FAULT;
            end else begin
              out_data  <= vec_in;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end else if (tmo_cnt <= 8'd1) begin
            vec_req    <= 1'b0;
            fault      <= 1'b1;
            fault_code <= CODE_TIMEOUT;
            state      <= ST_FAULT;
          end
        end

        ST_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_FAULT: begin
          vec_req   <= 1'b0;
          out_valid <= 1'b0;
          fault     <= 1'b1;
        end

        default: begin
          vec_req   <= 1'b0;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
